// File: rtl/enemy_pkg.sv
// Shared enemy definitions: state and type codes, sprite heights and per-type
// movement/cooldown tables used by the enemy sequencer and cat-side logic.
package enemy_pkg;

  localparam logic [2:0] ST_NONE   = 3'd0;
  localparam logic [2:0] ST_MOVE_0 = 3'd1;
  localparam logic [2:0] ST_MOVE_1 = 3'd2;
  localparam logic [2:0] ST_MOVE_2 = 3'd3;
  localparam logic [2:0] ST_ATT_CD = 3'd4;
  localparam logic [2:0] ST_ATT_0  = 3'd5;
  localparam logic [2:0] ST_ATT_1  = 3'd6;
  localparam logic [2:0] ST_ATT_2  = 3'd7;

  typedef enum logic [2:0] {
    CH_NONE     = 3'd0,
    KILLER_BIRD = 3'd1,
    WHITE_BEAR  = 3'd2,
    METAL_DUCK  = 3'd3,
    BLACK_BEAR  = 3'd4
  } enemy_type_e;

  localparam logic [6:0] HEIGHT_KILLER_BIRD = 7'd48;
  localparam logic [6:0] HEIGHT_WHITE_BEAR  = 7'd64;
  localparam logic [6:0] HEIGHT_METAL_DUCK  = 7'd40;
  localparam logic [6:0] HEIGHT_BLACK_BEAR  = 7'd64;

  localparam logic [1:0] SPEED_KILLER_BIRD = 2'd3;
  localparam logic [1:0] SPEED_WHITE_BEAR  = 2'd1;
  localparam logic [1:0] SPEED_METAL_DUCK  = 2'd1;
  localparam logic [1:0] SPEED_BLACK_BEAR  = 2'd2;

  localparam logic [5:0] CD_KILLER_BIRD = 6'd20;
  localparam logic [5:0] CD_WHITE_BEAR  = 6'd40;
  localparam logic [5:0] CD_METAL_DUCK  = 6'd30;
  localparam logic [5:0] CD_BLACK_BEAR  = 6'd50;

  typedef struct packed {
    logic [1:0] speed;
    logic [5:0] cooldown;
  } type_attr_t;

  function automatic logic is_valid_type(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd4);
  endfunction

  function automatic logic [2:0] next_move_state(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      ST_MOVE_0: n = ST_MOVE_1;
      ST_MOVE_1: n = ST_MOVE_2;
      default:   n = ST_MOVE_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/enemy_type_rom.sv
// Combinational enemy type -> {speed, cooldown} lookup.
module enemy_type_rom
  import enemy_pkg::*;
(
  input  logic [2:0] type_i,
  output type_attr_t attr_o
);

  // Unknown types walk at speed 0 with a one-tick cooldown so no frame counter can run away.
  always_comb begin
    attr_o = '{speed: 2'd0, cooldown: 6'd1};
    case (type_i)
      KILLER_BIRD: attr_o = '{speed: SPEED_KILLER_BIRD, cooldown: CD_KILLER_BIRD};
      WHITE_BEAR:  attr_o = '{speed: SPEED_WHITE_BEAR,  cooldown: CD_WHITE_BEAR};
      METAL_DUCK:  attr_o = '{speed: SPEED_METAL_DUCK,  cooldown: CD_METAL_DUCK};
      BLACK_BEAR:  attr_o = '{speed: SPEED_BLACK_BEAR,  cooldown: CD_BLACK_BEAR};
      default:     attr_o = '{speed: 2'd0, cooldown: 6'd1};
    endcase
  end

endmodule

// File: rtl/enemy_state_ctrl.sv
// Per-slot enemy lifecycle sequencer: spawn, walk, attack, cooldown, death.
// All sequencing advances on the frame tick; kill and spawn act on any cycle.
module enemy_state_ctrl
  import enemy_pkg::*;
#(
  parameter logic [9:0] SPAWN_X          = 10'd10,
  parameter logic [9:0] X_MAX            = 10'd520,
  parameter logic [5:0] MOVE_FRAME_TICKS = 6'd4,
  parameter logic [5:0] ATT_FRAME_TICKS  = 6'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       spawn,
  input  logic [2:0] spawn_type,
  input  logic       in_range,
  input  logic       kill,
  output logic [2:0] state,
  output logic [2:0] enemy_type,
  output logic [9:0] x_pos,
  output logic       active,
  output logic       hit
);

  logic [2:0]  state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [9:0]  x_pos_q, x_pos_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic        active_q, active_d;

  type_attr_t  attr_s;
  logic [10:0] x_sum_s;
  logic [9:0]  x_next_s;
  logic [5:0]  cnt_inc_s;
  logic        move_end_s, att_end_s, cd_end_s, spawn_ok_s;

  enemy_type_rom u_type_rom (
    .type_i (type_q),
    .attr_o (attr_s)
  );

  // Frame-end detection and saturating position step.
  always_comb begin
    cnt_inc_s  = cnt_q + 6'd1;
    move_end_s = (cnt_q == (MOVE_FRAME_TICKS - 6'd1));
    att_end_s  = (cnt_q == (ATT_FRAME_TICKS - 6'd1));
    cd_end_s   = (cnt_q == (attr_s.cooldown - 6'd1));
    spawn_ok_s = spawn && (state_q == ST_NONE) && is_valid_type(spawn_type);
    x_sum_s    = {1'b0, x_pos_q} + {9'd0, attr_s.speed};
    if (x_sum_s > {1'b0, X_MAX}) begin
      x_next_s = X_MAX;
    end else begin
      x_next_s = x_sum_s[9:0];
    end
  end

  // Next-state logic; an ignored spawn falls through so a same-cycle tick still advances.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    x_pos_d = x_pos_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    if (kill) begin
      state_d = ST_NONE;
      type_d  = 3'd0;
      cnt_d   = 6'd0;
    end else if (spawn_ok_s) begin
      state_d = ST_MOVE_0;
      type_d  = spawn_type;
      x_pos_d = SPAWN_X;
      cnt_d   = 6'd0;
    end else if (tick) begin
      case (state_q)
        ST_MOVE_0, ST_MOVE_1, ST_MOVE_2: begin
          if (in_range) begin
            state_d = ST_ATT_0;
            cnt_d   = 6'd0;
          end else begin
            x_pos_d = x_next_s;
            if (move_end_s) begin
              state_d = next_move_state(state_q);
              cnt_d   = 6'd0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end
        end
        ST_ATT_0: begin
          if (att_end_s) begin
            state_d = ST_ATT_1;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_ATT_1: begin
          if (att_end_s) begin
            state_d = ST_ATT_2;
            cnt_d   = 6'd0;
            hit_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_ATT_2: begin
          if (att_end_s) begin
            state_d = ST_ATT_CD;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_ATT_CD: begin
          if (cd_end_s) begin
            state_d = in_range ? ST_ATT_0 : ST_MOVE_0;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = ST_NONE;
          cnt_d   = 6'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    active_d = (state_d != ST_NONE);
  end

  // State, position, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_NONE;
      type_q   <= 3'd0;
      x_pos_q  <= 10'd0;
      cnt_q    <= 6'd0;
      hit_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      x_pos_q  <= x_pos_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      active_q <= active_d;
    end
  end

  assign state      = state_q;
  assign enemy_type = type_q;
  assign x_pos      = x_pos_q;
  assign active     = active_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_enemy_state_ctrl.sv
// Scoreboard bench for enemy_state_ctrl: each scenario builds a stimulus table,
// pushes expected outputs as it drives, and pops/compares after the clock edge.
module tb_enemy_state_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick, spawn, in_range, kill;
  logic [2:0] spawn_type;
  logic [2:0] state, enemy_type;
  logic [9:0] x_pos;
  logic       active, hit;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [2:0] st;
    logic [2:0] ty;
    logic [9:0] x;
    logic       hit;
    logic       act;
  } exp_t;

  typedef struct {
    logic       rs;
    logic       sp;
    logic [2:0] spt;
    logic       ir;
    logic       kl;
    logic       tk;
    logic       chk;
    exp_t       e;
  } stim_t;

  exp_t sb[$];

  enemy_state_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .spawn      (spawn),
    .spawn_type (spawn_type),
    .in_range   (in_range),
    .kill       (kill),
    .state      (state),
    .enemy_type (enemy_type),
    .x_pos      (x_pos),
    .active     (active),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rs, input logic sp, input logic [2:0] spt,
                               input logic ir, input logic kl, input logic tk, input logic chk,
                               input logic [2:0] est, input logic [2:0] ety, input logic [9:0] ex,
                               input logic eh, input logic ea);
    stim_t s;
    s.rs = rs; s.sp = sp; s.spt = spt; s.ir = ir; s.kl = kl; s.tk = tk; s.chk = chk;
    s.e.st = est; s.e.ty = ety; s.e.x = ex; s.e.hit = eh; s.e.act = ea;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rs; spawn = s.sp; spawn_type = s.spt;
    in_range = s.ir; kill = s.kl; tick = s.tk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(0, 0, 3'd0, 0, 0, 1, 1, 3'd0, 3'd0, 10'd0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 0, 1, 1, 3'd0, 3'd0, 10'd0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, 3'd0, 3'd0, 10'd0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) sb.push_back(tbl[i].e);
      apply(tbl[i]);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        checks++;
        if ({state, enemy_type, x_pos, hit, active} !== {e.st, e.ty, e.x, e.hit, e.act})
          $display("FAIL reset step %0d: got st=%0d ty=%0d x=%0d hit=%b act=%b, expected st=%0d ty=%0d x=%0d hit=%b act=%b",
                   i, state, enemy_type, x_pos, hit, active, e.st, e.ty, e.x, e.hit, e.act);
        else passed++;
      end
    end
  endtask

  task automatic test_walk();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, 1, 3'd2, 0, 0, 0, 1, 3'd1, 3'd2, 10'd10, 0, 1));
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, 3'(((k / 4) % 3) + 1), 3'd2, 10'(10 + k), 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 0, 1, 0, 1, 3'd0, 3'd0, 10'd22, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) sb.push_back(tbl[i].e);
      apply(tbl[i]);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        checks++;
        if ({state, enemy_type, x_pos, hit, active} !== {e.st, e.ty, e.x, e.hit, e.act})
          $display("FAIL walk step %0d: got st=%0d ty=%0d x=%0d hit=%b act=%b, expected st=%0d ty=%0d x=%0d hit=%b act=%b",
                   i, state, enemy_type, x_pos, hit, active, e.st, e.ty, e.x, e.hit, e.act);
        else passed++;
      end
    end
  endtask

  task automatic test_attack(input logic ir_cd);
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, 1, 3'd1, 1, 0, 0, 1, 3'd1, 3'd1, 10'd10, 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, 3'd5, 3'd1, 10'd10, 0, 1));
    // in_range dropped during the swing: the attack must still complete
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, (k < 3) ? 3'd5 : 3'd6, 3'd1, 10'd10, 0, 1));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, (k < 3) ? 3'd6 : 3'd7, 3'd1, 10'd10, (k == 3), 1));
    tbl.push_back(mk(1, 0, 3'd0, 0, 0, 0, 1, 3'd7, 3'd1, 10'd10, 0, 1));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, (k < 3) ? 3'd7 : 3'd4, 3'd1, 10'd10, 0, 1));
    for (int k = 1; k <= 20; k++)
      tbl.push_back(mk(1, 0, 3'd0, ir_cd, 0, 1, 1,
                       (k < 20) ? 3'd4 : (ir_cd ? 3'd5 : 3'd1), 3'd1, 10'd10, 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 0, 1, 0, 1, 3'd0, 3'd0, 10'd10, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) sb.push_back(tbl[i].e);
      apply(tbl[i]);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        checks++;
        if ({state, enemy_type, x_pos, hit, active} !== {e.st, e.ty, e.x, e.hit, e.act})
          $display("FAIL attack(ir_cd=%b) step %0d: got st=%0d ty=%0d x=%0d hit=%b act=%b, expected st=%0d ty=%0d x=%0d hit=%b act=%b",
                   ir_cd, i, state, enemy_type, x_pos, hit, active, e.st, e.ty, e.x, e.hit, e.act);
        else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    stim_t tbl[$];
    exp_t  e;
    int    xv;
    tbl.push_back(mk(1, 1, 3'd1, 0, 0, 0, 1, 3'd1, 3'd1, 10'd10, 0, 1));
    // Killer_Bird reaches 517, then 520 exactly, then 523 saturates back to 520
    for (int k = 1; k <= 172; k++) begin
      xv = 10 + 3 * k;
      if (xv > 520) xv = 520;
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, 3'(((k / 4) % 3) + 1), 3'd1, 10'(xv), 0, 1));
    end
    tbl.push_back(mk(1, 0, 3'd0, 0, 1, 0, 1, 3'd0, 3'd0, 10'd520, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) sb.push_back(tbl[i].e);
      apply(tbl[i]);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        checks++;
        if ({state, enemy_type, x_pos, hit, active} !== {e.st, e.ty, e.x, e.hit, e.act})
          $display("FAIL saturation step %0d: got st=%0d ty=%0d x=%0d hit=%b act=%b, expected st=%0d ty=%0d x=%0d hit=%b act=%b",
                   i, state, enemy_type, x_pos, hit, active, e.st, e.ty, e.x, e.hit, e.act);
        else passed++;
      end
    end
  endtask

  task automatic test_priority();
    stim_t tbl[$];
    exp_t  e;
    // kill on the tick that would end ATT_1: no hit, straight to idle
    tbl.push_back(mk(1, 1, 3'd1, 1, 0, 0, 1, 3'd1, 3'd1, 10'd10, 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, 3'd5, 3'd1, 10'd10, 0, 1));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, (k < 3) ? 3'd5 : 3'd6, 3'd1, 10'd10, 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 1, 1, 1, 1, 3'd0, 3'd0, 10'd10, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, 3'd0, 3'd0, 10'd10, 0, 0));
    // kill + spawn while idle
    tbl.push_back(mk(1, 1, 3'd3, 0, 1, 0, 1, 3'd0, 3'd0, 10'd10, 0, 0));
    // spawn during MOVE_1 is ignored; a same-cycle tick still advances
    tbl.push_back(mk(1, 1, 3'd2, 0, 0, 0, 1, 3'd1, 3'd2, 10'd10, 0, 1));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, (k < 4) ? 3'd1 : 3'd2, 3'd2, 10'(10 + k), 0, 1));
    tbl.push_back(mk(1, 1, 3'd1, 0, 0, 0, 1, 3'd2, 3'd2, 10'd14, 0, 1));
    tbl.push_back(mk(1, 1, 3'd4, 0, 0, 1, 1, 3'd2, 3'd2, 10'd15, 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 0, 1, 0, 1, 3'd0, 3'd0, 10'd15, 0, 0));
    // invalid spawn types while idle
    tbl.push_back(mk(1, 1, 3'd0, 0, 0, 0, 1, 3'd0, 3'd0, 10'd15, 0, 0));
    tbl.push_back(mk(1, 1, 3'd6, 0, 0, 0, 1, 3'd0, 3'd0, 10'd15, 0, 0));
    tbl.push_back(mk(1, 1, 3'd6, 0, 0, 1, 1, 3'd0, 3'd0, 10'd15, 0, 0));
    tbl.push_back(mk(1, 1, 3'd5, 1, 0, 1, 1, 3'd0, 3'd0, 10'd15, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) sb.push_back(tbl[i].e);
      apply(tbl[i]);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        checks++;
        if ({state, enemy_type, x_pos, hit, active} !== {e.st, e.ty, e.x, e.hit, e.act})
          $display("FAIL priority step %0d: got st=%0d ty=%0d x=%0d hit=%b act=%b, expected st=%0d ty=%0d x=%0d hit=%b act=%b",
                   i, state, enemy_type, x_pos, hit, active, e.st, e.ty, e.x, e.hit, e.act);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_attack();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, 1, 3'd1, 1, 0, 0, 1, 3'd1, 3'd1, 10'd10, 0, 1));
    tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, 3'd5, 3'd1, 10'd10, 0, 1));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, (k < 3) ? 3'd5 : 3'd6, 3'd1, 10'd10, 0, 1));
    tbl.push_back(mk(0, 0, 3'd0, 1, 0, 1, 1, 3'd0, 3'd0, 10'd0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 1, 0, 1, 1, 3'd0, 3'd0, 10'd0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 0, 3'd0, 1, 0, 1, 1, 3'd0, 3'd0, 10'd0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) sb.push_back(tbl[i].e);
      apply(tbl[i]);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        checks++;
        if ({state, enemy_type, x_pos, hit, active} !== {e.st, e.ty, e.x, e.hit, e.act})
          $display("FAIL reset_mid_attack step %0d: got st=%0d ty=%0d x=%0d hit=%b act=%b, expected st=%0d ty=%0d x=%0d hit=%b act=%b",
                   i, state, enemy_type, x_pos, hit, active, e.st, e.ty, e.x, e.hit, e.act);
        else passed++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; spawn = 1'b0; spawn_type = 3'd0; in_range = 1'b0; kill = 1'b0;
    test_reset();
    test_walk();
    test_attack(1'b1);
    test_attack(1'b0);
    test_saturation();
    test_priority();
    test_reset_mid_attack();
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
